// File: rtl/adc_distance_lut.sv
// Diagonal IR-sensor ADC sample to distance (cm): 33-entry breakpoint ROM with
// linear interpolation, two-stage pipeline, one sample accepted per cycle.
module adc_distance_lut (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] adc_data_diag,
  output logic [6:0]  distance_diag
);

  localparam int unsigned IN_W   = 16;
  localparam int unsigned OUT_W  = 7;
  localparam int unsigned FRAC_W = 10;
  localparam int unsigned IDX_W  = IN_W - 1 - FRAC_W;
  localparam int unsigned PROD_W = OUT_W + FRAC_W;

  logic [IDX_W-1:0]  seg_q;
  logic [FRAC_W-1:0] frac_q;
  logic [IDX_W:0]    seg_next;
  logic [OUT_W-1:0]  d_lo;
  logic [OUT_W-1:0]  d_hi;
  logic [OUT_W-1:0]  delta;
  logic [PROD_W-1:0] prod;
  logic [OUT_W-1:0]  step;
  logic [OUT_W-1:0]  dist_c;

  // Breakpoints D[k] = min(127, floor(1600/(k+1))), monotonically non-increasing
  function automatic logic [OUT_W-1:0] dist_rom(input logic [IDX_W:0] k);
    logic [OUT_W-1:0] d;
    case (k)
      6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5,
      6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11: d = 7'd127;
      6'd12: d = 7'd123;
      6'd13: d = 7'd114;
      6'd14: d = 7'd106;
      6'd15: d = 7'd100;
      6'd16: d = 7'd94;
      6'd17: d = 7'd88;
      6'd18: d = 7'd84;
      6'd19: d = 7'd80;
      6'd20: d = 7'd76;
      6'd21: d = 7'd72;
      6'd22: d = 7'd69;
      6'd23: d = 7'd66;
      6'd24: d = 7'd64;
      6'd25: d = 7'd61;
      6'd26: d = 7'd59;
      6'd27: d = 7'd57;
      6'd28: d = 7'd55;
      6'd29: d = 7'd53;
      6'd30: d = 7'd51;
      6'd31: d = 7'd50;
      default: d = 7'd48;
    endcase
    return d;
  endfunction

  // Interpolate between D[i] and D[i+1]; truncation keeps the result >= D[i+1]
  always_comb begin
    seg_next = {1'b0, seg_q} + (IDX_W+1)'(1);
    d_lo     = dist_rom({1'b0, seg_q});
    d_hi     = dist_rom(seg_next);
    delta    = d_lo - d_hi;
    prod     = PROD_W'(delta) * PROD_W'(frac_q);
    step     = OUT_W'(prod >> FRAC_W);
    dist_c   = d_lo - step;
  end

  // Negative samples clamp to zero before splitting into segment and fraction
  always_ff @(posedge clk) begin
    if (!reset) begin
      seg_q         <= '0;
      frac_q        <= '0;
      distance_diag <= '0;
    end else begin
      if (adc_data_diag[IN_W-1]) begin
        seg_q  <= '0;
        frac_q <= '0;
      end else begin
        seg_q  <= adc_data_diag[IN_W-2:FRAC_W];
        frac_q <= adc_data_diag[FRAC_W-1:0];
      end
      distance_diag <= dist_c;
    end
  end

endmodule

// File: tb/tb_adc_distance_lut.sv
// Scoreboarded bench for adc_distance_lut: directed boundary/interpolation/pipeline
// steps, random samples against an arithmetic reference, and mid-stream reset.
module tb_adc_distance_lut;

  logic        clk;
  logic        reset;
  logic [15:0] adc_data_diag;
  logic [6:0]  distance_diag;

  int checks   = 0;
  int failures = 0;

  logic [6:0] exp_q[$];

  adc_distance_lut dut (
    .clk           (clk),
    .reset         (reset),
    .adc_data_diag (adc_data_diag),
    .distance_diag (distance_diag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_d(input int k);
    int d;
    d = 1600 / (k + 1);
    return (d > 127) ? 127 : d;
  endfunction

  function automatic logic [6:0] ref_model(input logic [15:0] a);
    int v, i, f, lo, hi;
    v  = a[15] ? 0 : int'(a[14:0]);
    i  = v / 1024;
    f  = v % 1024;
    lo = ref_d(i);
    hi = ref_d(i + 1);
    return 7'(lo - (((lo - hi) * f) / 1024));
  endfunction

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_range(input string tag, input logic [6:0] obs);
    checks++;
    assert (obs >= 7'd48 && obs <= 7'd127) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=48..127", tag, obs);
    end
  endtask

  // One clock: drive inputs, queue the expectation, compare whatever matured
  task automatic step(input logic [15:0] a, input logic r, input logic [6:0] expv,
                      input string tag, input bit range_chk);
    adc_data_diag = a;
    reset         = r;
    if (!r) begin
      exp_q.delete();
      exp_q.push_back(7'd127);
    end else begin
      exp_q.push_back(expv);
    end
    @(posedge clk);
    #1;
    if (!r) begin
      check(tag, distance_diag, 7'd0);
    end else if (exp_q.size() >= 2) begin
      check(tag, distance_diag, exp_q.pop_front());
      if (range_chk) check_range({tag, "_range"}, distance_diag);
    end
  endtask

  initial begin
    logic [15:0] a;
    reset         = 1'b0;
    adc_data_diag = 16'h0;

    step(16'($urandom), 1'b0, 7'd0, "reset_hold0", 1'b0);
    step(16'hxxxx,      1'b0, 7'd0, "reset_hold1", 1'b0);

    step(16'h0000, 1'b1, 7'd127, "post_reset_d0", 1'b0);
    step(16'h0000, 1'b1, 7'd127, "adc_0000",      1'b0);
    step(16'h7FFF, 1'b1, 7'd49,  "adc_7fff",      1'b0);
    step(16'h7FFF, 1'b1, 7'd49,  "adc_7fff_hold", 1'b0);
    step(16'h8000, 1'b1, 7'd127, "adc_8000_neg",  1'b0);
    step(16'h4000, 1'b1, 7'd94,  "adc_4000",      1'b0);
    step(16'h4200, 1'b1, 7'd91,  "adc_4200",      1'b0);
    step(16'h3000, 1'b1, 7'd123, "adc_3000",      1'b0);
    step(16'h0400, 1'b1, 7'd127, "adc_0400",      1'b0);

    step(16'h0000, 1'b1, 7'd127, "pipe_0000", 1'b0);
    step(16'h7FFF, 1'b1, 7'd49,  "pipe_7fff", 1'b0);
    step(16'h4200, 1'b1, 7'd91,  "pipe_4200", 1'b0);
    step(16'h3000, 1'b1, 7'd123, "pipe_3000", 1'b0);

    for (int n = 0; n < 100; n++) begin
      a = 16'($urandom);
      step(a, 1'b1, ref_model(a), "random",      1'b1);
      step(a, 1'b1, ref_model(a), "random_hold", 1'b1);
    end

    step(16'h7FFF, 1'b1, 7'd49, "mid_pre0", 1'b0);
    step(16'h4200, 1'b1, 7'd91, "mid_pre1", 1'b0);
    step(16'h7FFF, 1'b0, 7'd0,  "mid_reset", 1'b0);
    step(16'h3000, 1'b1, 7'd123, "mid_resume_d0", 1'b0);
    step(16'h4000, 1'b1, 7'd94,  "mid_resume0",   1'b0);
    step(16'h7FFF, 1'b1, 7'd49,  "mid_resume1",   1'b0);
    step(16'h0000, 1'b1, 7'd127, "flush0",        1'b0);
    step(16'h0000, 1'b1, 7'd127, "flush1",        1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
